// File: rtl/prim_extremum_tree_pkg.sv
// Shared types and sizing helpers for the pipelined extremum (max/min) tree.
package prim_extremum_tree_pkg;

  typedef enum logic {
    ExtMax = 1'b0,
    ExtMin = 1'b1
  } ext_mode_e;

  // Register stages needed for a tree over num_src leaves cut every levels_per_stage levels.
  function automatic int unsigned num_stages(input int unsigned num_src,
                                             input int unsigned levels_per_stage);
    int unsigned levels;
    levels = $clog2(num_src);
    return (levels + levels_per_stage - 1) / levels_per_stage;
  endfunction

endpackage

// File: rtl/prim_extremum_tree_node.sv
// Compare-select node: prefers the valid child; on equal values the lower-index child (a) wins.
module prim_extremum_tree_node
  import prim_extremum_tree_pkg::*;
#(
  parameter int unsigned Width    = 8,
  parameter int unsigned SrcWidth = 5,
  parameter bit          Signed   = 1'b0
) (
  input  ext_mode_e           mode_i,
  input  logic                a_valid_i,
  input  logic [Width-1:0]    a_value_i,
  input  logic [SrcWidth-1:0] a_idx_i,
  input  logic                b_valid_i,
  input  logic [Width-1:0]    b_value_i,
  input  logic [SrcWidth-1:0] b_idx_i,
  output logic                valid_o,
  output logic [Width-1:0]    value_o,
  output logic [SrcWidth-1:0] idx_o
);

  logic b_gt, b_lt, pick_b;

  always_comb begin
    if (Signed) begin
      b_gt = $signed(b_value_i) > $signed(a_value_i);
      b_lt = $signed(b_value_i) < $signed(a_value_i);
    end else begin
      b_gt = b_value_i > a_value_i;
      b_lt = b_value_i < a_value_i;
    end
    pick_b  = b_valid_i & (~a_valid_i | ((mode_i == ExtMin) ? b_lt : b_gt));
    valid_o = a_valid_i | b_valid_i;
    value_o = pick_b ? b_value_i : a_value_i;
    idx_o   = pick_b ? b_idx_i : a_idx_i;
  end

endmodule

// File: rtl/prim_extremum_tree_pipe.sv
// Pipelined max/min tree with valid/ready flow control.
// Define PRIM_EXTREMUM_TREE_EMPTY_CNT_EN to count delivered results with no valid source.
module prim_extremum_tree_pipe
  import prim_extremum_tree_pkg::*;
#(
  parameter int unsigned NumSrc         = 32,
  parameter int unsigned Width          = 8,
  parameter int unsigned LevelsPerStage = 2,
  parameter bit          Signed         = 1'b0,
  localparam int unsigned SrcWidth      = $clog2(NumSrc)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NumSrc-1:0][Width-1:0] values_i,
  input  logic [NumSrc-1:0]            valid_i,
  input  logic                         mode_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [Width-1:0]             ext_value_o,
  output logic [SrcWidth-1:0]          ext_idx_o,
  output logic                         ext_valid_o,
  output logic [15:0]                  empty_cnt_o
);

  localparam int unsigned NumLevels = $clog2(NumSrc);
  localparam int unsigned NumStages = num_stages(NumSrc, LevelsPerStage);
  localparam int unsigned NumLeaves = 2 ** NumLevels;

  // Level l holds NumLeaves >> l live nodes; remaining entries are tied to zero.
  logic [Width-1:0]    lv_val  [NumLevels+1][NumLeaves];
  logic [SrcWidth-1:0] lv_idx  [NumLevels+1][NumLeaves];
  logic                lv_vld  [NumLevels+1][NumLeaves];
  ext_mode_e           lv_mode [NumLevels+1];

  logic [NumStages-1:0] stage_valid;
  logic [NumStages:0]   stage_ready;

  assign stage_ready[NumStages] = out_ready_i;
  assign lv_mode[0]             = ext_mode_e'(mode_i);

  for (genvar n = 0; n < NumLeaves; n++) begin : g_leaf
    assign lv_idx[0][n] = SrcWidth'(n);
    if (n < NumSrc) begin : g_src
      assign lv_val[0][n] = values_i[n];
      assign lv_vld[0][n] = valid_i[n];
    end else begin : g_pad
      assign lv_val[0][n] = '0;
      assign lv_vld[0][n] = 1'b0;
    end
  end

  for (genvar l = 0; l < NumLevels; l++) begin : g_level
    localparam int unsigned NumNodes = NumLeaves >> (l + 1);
    localparam int unsigned Stage    = l / LevelsPerStage;
    localparam bit Boundary = ((l + 1) % LevelsPerStage == 0) || (l + 1 == NumLevels);

    logic [Width-1:0]    nd_val [NumNodes];
    logic [SrcWidth-1:0] nd_idx [NumNodes];
    logic                nd_vld [NumNodes];

    for (genvar n = 0; n < NumNodes; n++) begin : g_node
      prim_extremum_tree_node #(
        .Width   (Width),
        .SrcWidth(SrcWidth),
        .Signed  (Signed)
      ) u_node (
        .mode_i   (lv_mode[l]),
        .a_valid_i(lv_vld[l][2*n]),
        .a_value_i(lv_val[l][2*n]),
        .a_idx_i  (lv_idx[l][2*n]),
        .b_valid_i(lv_vld[l][2*n+1]),
        .b_value_i(lv_val[l][2*n+1]),
        .b_idx_i  (lv_idx[l][2*n+1]),
        .valid_o  (nd_vld[n]),
        .value_o  (nd_val[n]),
        .idx_o    (nd_idx[n])
      );
    end

    if (Boundary) begin : g_reg
      logic      up_valid;
      logic      load;
      logic      vld_q;
      ext_mode_e mode_q;

      if (Stage == 0) begin : g_first
        assign up_valid = in_valid_i;
      end else begin : g_next
        assign up_valid = stage_valid[Stage-1];
      end

      assign load               = stage_ready[Stage] & up_valid;
      assign stage_valid[Stage] = vld_q;
      assign stage_ready[Stage] = ~vld_q | stage_ready[Stage+1];
      assign lv_mode[l+1]       = mode_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          vld_q  <= 1'b0;
          mode_q <= ExtMax;
        end else if (stage_ready[Stage]) begin
          vld_q <= up_valid;
          if (up_valid) mode_q <= lv_mode[l];
        end
      end

      for (genvar n = 0; n < NumNodes; n++) begin : g_node_q
        logic [Width-1:0]    val_q;
        logic [SrcWidth-1:0] idx_q;
        logic                nvld_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            val_q  <= '0;
            idx_q  <= '0;
            nvld_q <= 1'b0;
          end else if (load) begin
            val_q  <= nd_val[n];
            idx_q  <= nd_idx[n];
            nvld_q <= nd_vld[n];
          end
        end
        assign lv_val[l+1][n] = val_q;
        assign lv_idx[l+1][n] = idx_q;
        assign lv_vld[l+1][n] = nvld_q;
      end
    end else begin : g_comb
      assign lv_mode[l+1] = lv_mode[l];
      for (genvar n = 0; n < NumNodes; n++) begin : g_node_c
        assign lv_val[l+1][n] = nd_val[n];
        assign lv_idx[l+1][n] = nd_idx[n];
        assign lv_vld[l+1][n] = nd_vld[n];
      end
    end

    for (genvar n = NumNodes; n < NumLeaves; n++) begin : g_unused
      assign lv_val[l+1][n] = '0;
      assign lv_idx[l+1][n] = '0;
      assign lv_vld[l+1][n] = 1'b0;
    end
  end

  assign in_ready_o  = stage_ready[0] & ~rst_i;
  assign out_valid_o = stage_valid[NumStages-1];
  assign ext_value_o = lv_val[NumLevels][0];
  assign ext_idx_o   = lv_idx[NumLevels][0];
  assign ext_valid_o = lv_vld[NumLevels][0];

`ifdef PRIM_EXTREMUM_TREE_EMPTY_CNT_EN
  logic [15:0] empty_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      empty_cnt_q <= '0;
    end else if (out_valid_o && out_ready_i && !ext_valid_o && empty_cnt_q != 16'hFFFF) begin
      empty_cnt_q <= empty_cnt_q + 16'd1;
    end
  end
  assign empty_cnt_o = empty_cnt_q;
`else
  assign empty_cnt_o = '0;
`endif

endmodule

// File: tb/tb_prim_extremum_tree_pipe.sv
// Directed bench for prim_extremum_tree_pipe: latency, modes, empty, backpressure, signed, reset.
module tb_prim_extremum_tree_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance: NumSrc=5, LevelsPerStage=1 -> 3 stages.
  logic            in_valid, in_ready, mode, out_valid, out_ready, ext_valid;
  logic [4:0][7:0] vals;
  logic [4:0]      valid;
  logic [7:0]      ext_value;
  logic [2:0]      ext_idx;
  logic [15:0]     empty_cnt;

  // Two-source instances, signed and unsigned, single stage.
  logic            s_in_valid, s_mode;
  logic [1:0][7:0] s_vals;
  logic [1:0]      s_valid;
  logic            s1_in_ready, s1_out_valid, s1_ext_valid, s1_idx;
  logic            s0_in_ready, s0_out_valid, s0_ext_valid, s0_idx;
  logic [7:0]      s1_value, s0_value;
  logic [15:0]     s1_cnt, s0_cnt;

  prim_extremum_tree_pipe #(
    .NumSrc(5), .Width(8), .LevelsPerStage(1), .Signed(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .values_i(vals), .valid_i(valid), .mode_i(mode), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .ext_value_o(ext_value), .ext_idx_o(ext_idx),
    .ext_valid_o(ext_valid), .empty_cnt_o(empty_cnt)
  );

  prim_extremum_tree_pipe #(
    .NumSrc(2), .Width(8), .LevelsPerStage(2), .Signed(1'b1)
  ) dut_s1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(s_in_valid), .in_ready_o(s1_in_ready),
    .values_i(s_vals), .valid_i(s_valid), .mode_i(s_mode), .out_valid_o(s1_out_valid),
    .out_ready_i(1'b1), .ext_value_o(s1_value), .ext_idx_o(s1_idx),
    .ext_valid_o(s1_ext_valid), .empty_cnt_o(s1_cnt)
  );

  prim_extremum_tree_pipe #(
    .NumSrc(2), .Width(8), .LevelsPerStage(2), .Signed(1'b0)
  ) dut_s0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(s_in_valid), .in_ready_o(s0_in_ready),
    .values_i(s_vals), .valid_i(s_valid), .mode_i(s_mode), .out_valid_o(s0_out_valid),
    .out_ready_i(1'b1), .ext_value_o(s0_value), .ext_idx_o(s0_idx),
    .ext_valid_o(s0_ext_valid), .empty_cnt_o(s0_cnt)
  );

`ifdef PRIM_EXTREMUM_TREE_EMPTY_CNT_EN
  localparam logic [15:0] EmptyAfterOne = 16'd1;
`else
  localparam logic [15:0] EmptyAfterOne = 16'd0;
`endif

  int passed = 0;
  int total  = 0;
  int acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Transaction k: only source k%5 valid, carrying 16*k+1.
  task automatic tx(input int k);
    in_valid = 1'b1;
    mode     = 1'b0;
    valid    = 5'b00001 << (k % 5);
    for (int i = 0; i < 5; i++) vals[i] = 8'(16 * k + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; valid = '0; vals = '0;
    s_in_valid = 1'b0; s_mode = 1'b0; s_vals = '0; s_valid = '0;
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_value", ext_value, 0);
    chk("rst_idx", ext_idx, 0);
    chk("rst_ext_valid", ext_valid, 0);
    chk("rst_empty_cnt", empty_cnt, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Latency: accepted at the next edge, result visible three cycles after presentation.
    vals = {8'd3, 8'd7, 8'd40, 8'd40, 8'd10}; valid = 5'h1f; mode = 1'b0; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("lat_c1_out_valid", out_valid, 0);
    tick();
    chk("lat_c2_out_valid", out_valid, 0);
    tick();
    chk("max_out_valid", out_valid, 1);
    chk("max_value", ext_value, 40);
    chk("max_idx_tie_low", ext_idx, 1);
    chk("max_ext_valid", ext_valid, 1);
    tick();
    chk("max_popped", out_valid, 0);

    // Back-to-back: max, min, empty; mode travels with each transaction.
    in_valid = 1'b1; mode = 1'b0;
    tick(); mode = 1'b1;
    tick(); mode = 1'b0; valid = '0;
    tick(); in_valid = 1'b0;
    chk("b2b_max_value", ext_value, 40);
    chk("b2b_max_idx", ext_idx, 1);
    tick();
    chk("min_out_valid", out_valid, 1);
    chk("min_value", ext_value, 3);
    chk("min_idx", ext_idx, 4);
    tick();
    chk("empty_out_valid", out_valid, 1);
    chk("empty_ext_valid", ext_valid, 0);
    chk("empty_idx", ext_idx, 0);
    chk("empty_value", ext_value, 10);
    chk("empty_cnt_before", empty_cnt, 0);
    tick();
    chk("empty_drained", out_valid, 0);
    chk("empty_cnt_after", empty_cnt, EmptyAfterOne);

    // Signed versus unsigned compare of 8'hFF against 8'h01.
    s_vals = {8'h01, 8'hFF}; s_valid = 2'b11; s_in_valid = 1'b1;
    tick(); s_in_valid = 1'b0;
    chk("signed_out_valid", s1_out_valid, 1);
    chk("signed_idx", s1_idx, 1);
    chk("signed_value", s1_value, 8'h01);
    chk("unsigned_idx", s0_idx, 0);
    chk("unsigned_value", s0_value, 8'hFF);
    tick();
    chk("signed_popped", s1_out_valid, 0);

    // Backpressure: six cycles of offers with the sink stalled fill exactly three stages.
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      tx(acc);
      if (in_ready) acc++;
      tick();
    end
    chk("stall_accepted", acc, 3);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_hold_idx", ext_idx, 0);
    chk("stall_hold_value", ext_value, 1);

    // Pop and push in the same cycle while full.
    tx(3); out_ready = 1'b1;
    #1;
    chk("full_pushpop_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    chk("drain1_idx", ext_idx, 1);
    chk("drain1_value", ext_value, 17);
    tick();
    chk("drain2_idx", ext_idx, 2);
    chk("drain2_value", ext_value, 33);
    tick();
    chk("drain3_valid", out_valid, 1);
    chk("drain3_idx", ext_idx, 3);
    chk("drain3_value", ext_value, 49);
    tick();
    chk("drain_done", out_valid, 0);

    // Reset while two transactions are in flight.
    tx(1); tick();
    tx(2); tick();
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    tick(); rst = 1'b0;
    tick();
    chk("midrst_release_ready", in_ready, 1);
    chk("midrst_empty_cnt", empty_cnt, 0);
    for (int c = 0; c < 4; c++) begin
      chk("midrst_no_stale", out_valid, 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prim_extremum_tree_pipe.md
PRIM_EXTREMUM_TREE_PIPE -- requirements
Module: prim_extremum_tree_pipe

Interface
REQ-001 SHALL have parameter NumSrc, default 32: number of sources, minimum 2.
REQ-002 SHALL have parameter Width, default 8: bit width of each value.
REQ-003 SHALL have parameter LevelsPerStage, default 2: tree levels per register stage, minimum 1.
REQ-004 SHALL have parameter bit Signed, default 0: 1 selects two's-complement compare, 0 selects unsigned compare.
REQ-005 SHALL have derived localparams SrcWidth = $clog2(NumSrc), NumLevels = $clog2(NumSrc), NumStages = ceil(NumLevels / LevelsPerStage).
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port in_valid_i, input, 1 bit: input transaction offered.
REQ-009 SHALL have port in_ready_o, output, 1 bit: input transaction accepted when high together with in_valid_i.
REQ-010 SHALL have port values_i, input, NumSrc x Width: source values.
REQ-011 SHALL have port valid_i, input, NumSrc bits: per-source participation mask.
REQ-012 SHALL have port mode_i, input, 1 bit: 0 selects maximum, 1 selects minimum; sampled per transaction.
REQ-013 SHALL have port out_valid_o, output, 1 bit: a result is presented.
REQ-014 SHALL have port out_ready_i, input, 1 bit: downstream accepts the result.
REQ-015 SHALL have port ext_value_o, output, Width bits: the selected extremum value.
REQ-016 SHALL have port ext_idx_o, output, SrcWidth bits: index of the selected source.
REQ-017 SHALL have port ext_valid_o, output, 1 bit: at least one source was valid in the transaction.
REQ-018 SHALL have port empty_cnt_o, output, 16 bits: count of delivered results with no valid source.

Function
REQ-019 SHALL implement a binary tree padded to 2**NumLevels leaves, with padded leaves invalid and zero.
REQ-020 SHALL give each node priority to the valid child; when both children are valid, it SHALL pick child 1 only if child 1 is strictly greater (max mode) or strictly less (min mode); ties SHALL go to the lower index.
REQ-021 SHALL leave ext_idx_o = 0, ext_value_o = values_i[0] of that transaction and ext_valid_o = 0 when no source is valid.
REQ-022 SHALL register stage boundaries after every LevelsPerStage levels and SHALL register the root; mode SHALL be carried through each stage with the data.
REQ-023 SHALL have a latency of exactly NumStages cycles from acceptance to out_valid_o when unstalled, with a throughput of one transaction per cycle.
REQ-024 SHALL compute the ready of stage s as !stage_valid[s] | ready[s+1]; in_ready_o SHALL be the stage-0 ready, and the last stage SHALL use out_ready_i.
REQ-025 SHALL hold ext_* outputs stable while out_valid_o is high and out_ready_i is low; it SHALL neither drop nor duplicate transactions, and SHALL preserve order.
REQ-026 SHALL accept a new transaction when the pipeline is full and out_ready_i is high in the same cycle (simultaneous pop and push).
REQ-027 SHALL compare using $signed operands when Signed = 1.

Reset
REQ-028 SHALL, while rst_i is high, clear all stage valids and set out_valid_o = 0, in_ready_o = 0, ext_value_o = 0, ext_idx_o = 0, ext_valid_o = 0 and empty_cnt_o = 0.
REQ-029 SHALL discard all in-flight transactions when rst_i asserts mid-operation, and SHALL have in_ready_o = 1 in the first cycle after deassertion.

Configuration
REQ-030 SHALL, with PRIM_EXTREMUM_TREE_EMPTY_CNT_EN defined, increment empty_cnt_o on each out_valid_o and out_ready_i handshake where ext_valid_o = 0, saturating at 16'hFFFF.
REQ-031 SHALL, without PRIM_EXTREMUM_TREE_EMPTY_CNT_EN, tie empty_cnt_o to 0 and contain no counter flops.

Structure
REQ-032 SHALL take the mode enum (ExtMax = 0, ExtMin = 1) and a num_stages(NumSrc, LevelsPerStage) function from package prim_extremum_tree_pkg.
REQ-033 SHALL implement the per-node compare-select in sub-module prim_extremum_tree_node, parametrised by Width, SrcWidth and Signed.

Verification
REQ-034 SHALL check: NumSrc=5, Width=8, LevelsPerStage=1, values {10,40,40,7,3}, all valid, max -> 3 cycles later ext_value_o=40, ext_idx_o=1, ext_valid_o=1.
REQ-035 SHALL check: the same values with mode_i=1 -> ext_value_o=3, ext_idx_o=4.
REQ-036 SHALL check: valid_i=0 with EMPTY_CNT_EN defined -> ext_valid_o=0, ext_idx_o=0, ext_value_o=10, and empty_cnt_o goes from 0 to 1 after the handshake.
REQ-037 SHALL check: out_ready_i low for 6 cycles while in_valid_i is high continuously -> exactly 3 transactions accepted, in_ready_o=0 afterwards; then out_ready_i high -> results drain in order with no loss.
REQ-038 SHALL check: Signed=1, values {8'hFF, 8'h01}, max -> ext_idx_o=1; with Signed=0 -> ext_idx_o=0.
REQ-039 SHALL check: rst_i pulsed while 2 transactions are in flight -> out_valid_o=0 immediately, no stale result afterwards, and in_ready_o=1 one cycle after release.
